// File: rtl/alu_pkg.sv
// Shared ALU definitions: shift function codes, shifter FSM states
// and shift-amount width.
package alu_pkg;

   localparam int SHAMT_W = 5;

   localparam logic [1:0] FN_SRL = 2'b00;
   localparam logic [1:0] FN_SLL = 2'b01;
   localparam logic [1:0] FN_SRA = 2'b10;
   localparam logic [1:0] FN_ROR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } shst_e;

endpackage

// File: rtl/shift_seq_if.sv
// Valid/ready bundle between the execute stage (master) and the
// iterative shifter (slave).
interface shift_seq_if #(
   parameter int WIDTH = 32
);
   import alu_pkg::*;

   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   a;
   logic [SHAMT_W-1:0] b;
   logic [1:0]         funct;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   shtres;
   logic               busy;

   modport master (
      output in_valid, a, b, funct, out_ready,
      input  in_ready, out_valid, shtres, busy
   );

   modport slave (
      input  in_valid, a, b, funct, out_ready,
      output in_ready, out_valid, shtres, busy
   );

endinterface

// File: rtl/shift_step.sv
// Combinational shift step: moves x by k bit positions (k = 0..4)
// according to op. Pure bit manipulation, no flags.
module shift_step
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] x_i,
   input  logic [1:0]       op_i,
   input  logic [2:0]       k_i,
   output logic [WIDTH-1:0] y_o
);

   logic [2*WIDTH-1:0] rot;

   // rotate by shifting a doubled copy; low half is the result
   assign rot = {x_i, x_i} >> k_i;

   // select the shift flavour
   always_comb begin
      y_o = x_i;
      case (op_i)
         FN_SRL:  y_o = x_i >> k_i;
         FN_SLL:  y_o = x_i << k_i;
         FN_SRA:  y_o = $unsigned($signed(x_i) >>> k_i);
         FN_ROR:  y_o = rot[WIDTH-1:0];
         default: y_o = x_i;
      endcase
   end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle iterative shifter (SRL/SLL/SRA/ROR), valid/ready on both
// sides. Define SHIFT_SEQ_STEP4_EN to move up to four bits per cycle.
module shift_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic        clk,
   input  logic        rst,
   shift_seq_if.slave  bus
);

   shst_e              state_q, state_d;
   logic [SHAMT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic [1:0]         op_q, op_d;
   logic [2:0]         k;
   logic [WIDTH-1:0]   step_y;

`ifdef SHIFT_SEQ_STEP4_EN
   // move min(count,4) bits this cycle
   assign k = (count_q > SHAMT_W'(4)) ? 3'd4 : count_q[2:0];
`else
   // one bit per cycle
   assign k = 3'd1;
`endif

   shift_step #(.WIDTH(WIDTH)) u_step (
      .x_i  (res_q),
      .op_i (op_q),
      .k_i  (k),
      .y_o  (step_y)
   );

   // state, count, result and opcode registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         res_q   <= '0;
         op_q    <= FN_SRL;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         res_q   <= res_d;
         op_q    <= op_d;
      end
   end

   // next-state: accept, iterate, hold until consumer takes result
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      res_d   = res_q;
      op_d    = op_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               res_d   = bus.a;
               count_d = bus.b;
               op_d    = bus.funct;
               state_d = (bus.b == '0) ? ST_DONE : ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            res_d   = step_y;
            count_d = count_q - SHAMT_W'(k);
            if (count_q == SHAMT_W'(k))
               state_d = ST_DONE;
         end
         ST_DONE: begin
            if (bus.out_ready)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // handshake outputs decoded from state
   always_comb begin
      bus.in_ready  = (state_q == ST_IDLE);
      bus.out_valid = (state_q == ST_DONE);
      bus.busy      = (state_q != ST_IDLE);
      bus.shtres    = res_q;
   end

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq: directed table, DONE-hold and
// mid-shift reset sequences, then random ops against a reference model.
module tb_shift_seq;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   shift_seq_if #(.WIDTH(32)) bus ();

   shift_seq #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [31:0] a;
      logic [4:0]  b;
      logic [1:0]  fn;
      logic [31:0] exp;
   } vec_t;

   vec_t vt[10];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // behavioural reference from the function definitions
   function automatic logic [31:0] mdl(input logic [31:0] a,
                                       input int b, input logic [1:0] fn);
      logic [31:0] r;
      case (fn)
         2'd0: r = a >> b;
         2'd1: r = a << b;
         2'd2: r = a[31] ? ((a >> b) | ~(32'hFFFF_FFFF >> b)) : (a >> b);
         default: r = (b == 0) ? a : ((a >> b) | (a << (32 - b)));
      endcase
      return r;
   endfunction

   // clock edges after the accept edge until out_valid
   function automatic int exp_lat(input int b);
`ifdef SHIFT_SEQ_STEP4_EN
      return (b + 3) / 4;
`else
      return b;
`endif
   endfunction

   // issue one op, wait for result, check value/latency, drain it
   task automatic run_op(input string nm, input logic [31:0] a,
                         input logic [4:0] b, input logic [1:0] fn,
                         input logic [31:0] exp);
      int e;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a        = a;
      bus.b        = b;
      bus.funct    = fn;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.a        = $urandom;
      bus.b        = 5'($urandom);
      e = 0;
      while (!bus.out_valid && e < 200) begin
         @(posedge clk);
         #1;
         e++;
      end
      chk({nm, " lat"}, 32'(e), 32'(exp_lat(int'(b))));
      chk({nm, " res"}, bus.shtres, exp);
      chk({nm, " rdy"}, {31'd0, bus.in_ready}, 32'd0);
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      chk({nm, " idle"}, {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
   endtask

   initial begin
      logic [31:0] ra, hold;
      logic [4:0]  rb;
      logic [1:0]  rf;
      int          e, seen;

      vt[0] = '{32'h8000_0001, 5'd1,  2'd0, 32'h4000_0000};
      vt[1] = '{32'h8000_0000, 5'd4,  2'd2, 32'hF800_0000};
      vt[2] = '{32'h0000_00F1, 5'd31, 2'd3, 32'h0000_01E2};
      vt[3] = '{32'h0000_00F1, 5'd31, 2'd1, 32'h8000_0000};
      vt[4] = '{32'hDEAD_BEEF, 5'd0,  2'd0, 32'hDEAD_BEEF};
      vt[5] = '{32'hDEAD_BEEF, 5'd0,  2'd1, 32'hDEAD_BEEF};
      vt[6] = '{32'hDEAD_BEEF, 5'd0,  2'd2, 32'hDEAD_BEEF};
      vt[7] = '{32'hDEAD_BEEF, 5'd0,  2'd3, 32'hDEAD_BEEF};
      vt[8] = '{32'h8000_0000, 5'd31, 2'd2, 32'hFFFF_FFFF};
      vt[9] = '{32'h1234_5678, 5'd4,  2'd3, 32'h8123_4567};

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.funct     = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset flags", {29'd0, bus.in_ready, bus.out_valid, bus.busy},
          32'd4);
      chk("reset shtres", bus.shtres, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 10; i++)
         run_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].fn,
                vt[i].exp);

      // result held in DONE while consumer stalls; new input ignored
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a        = 32'hF000_000F;
      bus.b        = 5'd3;
      bus.funct    = 2'd2;
      @(posedge clk);
      #1;
      bus.a = 32'h0000_0001;
      bus.b = 5'd0;
      e = 0;
      while (!bus.out_valid && e < 200) begin
         @(posedge clk);
         #1;
         e++;
      end
      hold = mdl(32'hF000_000F, 3, 2'd2);
      chk("hold res", bus.shtres, hold);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("hold c%0d", i),
             {bus.shtres[31:3], bus.out_valid, bus.in_ready, bus.busy},
             {hold[31:3], 3'b101});
      end
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("hold after", {30'd0, bus.busy, bus.in_ready}, 32'd1);

      // reset mid-shift discards the op
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a        = 32'hAAAA_5555;
      bus.b        = 5'd20;
      bus.funct    = 2'd3;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      chk("pre-rst busy", {31'd0, bus.busy}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rst flags", {29'd0, bus.in_ready, bus.out_valid, bus.busy},
          32'd4);
      chk("rst shtres", bus.shtres, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid || bus.busy) seen++;
      end
      chk("post-rst quiet", 32'(seen), 32'd0);

      // random ops against the reference model
      for (int i = 0; i < 40; i++) begin
         ra = $urandom;
         rb = 5'($urandom_range(0, 31));
         rf = 2'($urandom_range(0, 3));
         run_op($sformatf("rnd%0d", i), ra, rb, rf, mdl(ra, int'(rb), rf));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
